// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux block.
package stream_mux_pkg;

  localparam int NR_CH_DEF    = 4;
  localparam int DATA_LEN_DEF = 8;

  // Channel index width: $clog2(n), never narrower than 1 bit.
  function automatic int sel_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: starts one past ptr, wraps, first request wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NR_CH   = NR_CH_DEF,
  localparam int SEL_LEN = sel_w(NR_CH)
) (
  input  logic [NR_CH-1:0]   req,
  input  logic [SEL_LEN-1:0] ptr,
  output logic               gnt_vld,
  output logic [SEL_LEN-1:0] gnt_idx
);

  logic [SEL_LEN-1:0] idx;

  // Walk from lowest priority (ptr itself) to highest (ptr+1) so the last hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NR_CH; k >= 1; k--) begin
      idx = SEL_LEN'((int'(ptr) + k) % NR_CH);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output.
// Define STREAM_MUX_SEL_EN to add a sel port that forces the granted channel.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int NR_CH    = NR_CH_DEF,
  parameter  int DATA_LEN = DATA_LEN_DEF,
  localparam int SEL_LEN  = sel_w(NR_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef STREAM_MUX_SEL_EN
  input  logic [SEL_LEN-1:0]        sel,
`endif
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [SEL_LEN-1:0]        out_ch
);

  logic [SEL_LEN-1:0] ptr;
  logic               gnt_vld;
  logic [SEL_LEN-1:0] gnt_idx;
  logic               ld_ok;
  logic               xfer;

`ifdef STREAM_MUX_SEL_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = sel;
    if (int'(sel) < NR_CH) gnt_vld = in_valid[sel];
  end
`else
  rr_arbiter #(.NR_CH(NR_CH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );
`endif

  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign ld_ok    = !out_valid || out_ready;
  assign xfer     = rst_n && gnt_vld && ld_ok;
  assign in_ready = xfer ? ({{(NR_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_LEN'(NR_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*DATA_LEN +: DATA_LEN];
      out_ch    <= gnt_idx;
      ptr       <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel stream multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. It generalises the single-bit 2:1 selector to NR_CH channels of DATA_LEN bits. Channel selection comes from an internal fair arbiter instead of a static select line. It sits between several producer streams and one consumer, for example request merging in front of a shared bus or memory port.

## Interface
- NR_CH, default 4: number of input channels; must be at least 2.
- DATA_LEN, default 8: payload width in bits.
- SEL_LEN, derived as $clog2(NR_CH): channel index width.
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: reset; asynchronous and active-low.
- in_valid, input, NR_CH: per-channel valid; bit i belongs to channel i.
- in_ready, output, NR_CH: per-channel ready.
- in_data, input, NR_CH*DATA_LEN: packed payloads; channel i occupies bits [i*DATA_LEN +: DATA_LEN].
- out_valid, output, 1: output stage holds a beat.
- out_ready, input, 1: consumer accepts the beat.
- out_data, output, DATA_LEN: registered payload.
- out_ch, output, SEL_LEN: source channel index of out_data.
- sel, input, SEL_LEN: forced channel; present only with STREAM_MUX_SEL_EN.

## Operation
- Output stage: one entry. It can load when `ld_ok = !out_valid || out_ready`.
- Arbitration: a combinational search over in_valid. The search starts at channel (ptr+1) mod NR_CH and wraps through NR_CH-1 to 0. The first set bit wins.
- ptr holds the last granted channel; reset value NR_CH-1, so channel 0 has first priority after reset.
- in_ready[g] = ld_ok for the granted channel g; all other in_ready bits are 0.
- If no in_valid bit is set, there is no grant and all in_ready bits are 0. in_ready may depend on in_valid; no producer may make in_valid depend on in_ready.
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. On that edge: out_data <= channel i payload, out_ch <= i, out_valid <= 1, ptr <= i.
- Output accepted (out_valid && out_ready) with no new transfer: out_valid <= 0. out_data and out_ch keep their values.
- Simultaneous output accept and new input transfer: the new beat replaces the old one in the same cycle. No bubble is inserted.
- Stall (out_valid && !out_ready): out_valid, out_data and out_ch hold; all in_ready bits are 0; ptr holds.
- A producer holding in_valid while stalled keeps its request. The grant may move to another channel only after a transfer updates ptr.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NR_CH-1,0,...

## Timing
- Latency: an input transfer at edge k makes out_valid=1 with that data after edge k. Latency is 1 cycle.
- Throughput: 1 beat per cycle while out_ready=1.
- Combinational paths: in_valid and out_ready to in_ready. There is no combinational path from input data to output.
- Reset, asserted at any time including mid-stall: immediately out_valid=0, out_data=0, out_ch=0, ptr=NR_CH-1. Any beat held in the output stage is discarded. in_ready bits are 0 while rst_n=0.
- Reset deassertion is synchronised to clk upstream of this block.

## Configuration
- STREAM_MUX_SEL_EN defined: the sel port exists and the round-robin search is bypassed.
  - The grant goes to channel sel only when in_valid[sel]=1; otherwise there is no grant.
  - A sel value of NR_CH or above gives no grant.
  - ptr still updates on transfers but has no effect.
- STREAM_MUX_SEL_EN undefined: no sel port; round-robin arbitration as described in Operation.

## Structure
- Package stream_mux_pkg holds:
  - the default NR_CH and DATA_LEN constants;
  - a width function returning max(1, $clog2(n)).
- Sub-module rr_arbiter: parameter NR_CH.
  - Inputs: req[NR_CH], ptr[SEL_LEN].
  - Outputs: gnt_vld, gnt_idx[SEL_LEN].
  - Purely combinational. The top level owns ptr and the output register.

## Test plan
- Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release with all channels valid, the first grant is channel 0.
- Round-robin: NR_CH=4, in_valid=4'b1111, out_ready=1, channel i data=8'hA0+i, for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and out_data 8'hA0..8'hA3 repeating.
- Sparse and wrap: in_valid=4'b1001 continuously, ptr=0 after a channel-0 grant -> next grant is 3, then 0, then 3. Channels 1 and 2 never see in_ready=1.
- Backpressure: beat 8'h55 in the output stage, out_ready=0 for 3 cycles -> out_data stays 8'h55, all in_ready=0. On the cycle out_ready=1, the next beat loads with no gap.
- Mid-stall reset: pulse rst_n low for 1 cycle while out_valid=1 and out_ready=0 -> out_valid falls without waiting for a clock edge, and the held beat is never delivered.
- STREAM_MUX_SEL_EN: sel=2 with in_valid=4'b0101 -> only in_ready[2]=1 and out_ch=2. sel=1 with the same in_valid -> no grant and out_valid stays 0.
